loop_update_sched: RTL and testbench
====================================

LOOP_UPDATE_SCHED -- requirements
Module: loop_update_sched

Interface
REQ-001 The block SHALL have parameter Cfg, default build_config(TestCfg), meaning the global core configuration record.
REQ-002 The block SHALL have parameter NUM_LANES, default 4, meaning the number of commit lanes presenting resolved branches per cycle.
REQ-003 The block SHALL have parameter DEPTH, default 8, meaning the update-queue entries; the value SHALL be a power of two and at least NUM_LANES.
REQ-004 The block SHALL have port clk_i, input, 1 bit, meaning the single clock; all state SHALL be on its rising edge.
REQ-005 The block SHALL have port rst_ni, input, 1 bit, meaning the reset; reset SHALL be asynchronous and active-low.
REQ-006 The block SHALL have port commit_valid_i, input, NUM_LANES bits, meaning per-lane retired-instruction valid.
REQ-007 The block SHALL have port commit_pc_i, input, NUM_LANES x 32 bits, meaning per-lane instruction PC.
REQ-008 The block SHALL have port commit_is_cond_i, input, NUM_LANES bits, meaning the lane holds a conditional branch.
REQ-009 The block SHALL have port commit_taken_i, input, NUM_LANES bits, meaning the resolved direction.
REQ-010 The block SHALL have port commit_ready_o, output, 1 bit, meaning the block accepts a full commit group this cycle.
REQ-011 The block SHALL have port flush_i, input, 1 bit, meaning discard all queued updates.
REQ-012 The block SHALL have port update_valid_o, output, 1 bit, meaning a loop-predictor training request.
REQ-013 The block SHALL have port update_pc_o, output, 32 bits, meaning the training PC.
REQ-014 The block SHALL have port update_is_cond_o, output, 1 bit, meaning the conditional flag; it SHALL be 1 whenever update_valid_o is 1.
REQ-015 The block SHALL have port update_taken_o, output, 1 bit, meaning the training direction.
REQ-016 The block SHALL have port occupancy_o, output, clog2(DEPTH)+1 bits, meaning the current queue count.

Function
REQ-017 A lane SHALL qualify only when commit_valid_i, commit_is_cond_i and commit_ready_o are all 1.
REQ-018 Qualifying lanes SHALL be enqueued in one cycle, compacted, in ascending lane order (lane 0 oldest); non-qualifying lanes SHALL leave no holes.
REQ-019 commit_ready_o SHALL be combinational from registered state: 1 iff DEPTH - count >= NUM_LANES; groups presented while it is 0 SHALL be dropped without any state change.
REQ-020 update_valid_o SHALL equal (count != 0) with the head entry on pc/taken, so an entry enqueued at edge N is visible after edge N and earliest consumed at edge N+1; latency is 1 cycle.
REQ-021 The loop predictor has no ready, so exactly one entry SHALL be popped at every edge where update_valid_o is 1.
REQ-022 On a simultaneous push of k entries and a pop, count SHALL become count + k - 1; the head SHALL advance before the new entries are ordered behind it.
REQ-023 Read and write pointers SHALL be clog2(DEPTH) bits and wrap modulo DEPTH; count SHALL never exceed DEPTH.
REQ-024 When update_valid_o is 0, update_pc_o and update_taken_o SHALL be driven 0.
REQ-025 flush_i at an edge SHALL set count and both pointers to 0, and SHALL discard both that cycle's push and that cycle's pop; update_valid_o SHALL be 0 in the next cycle.
REQ-026 Training order to the predictor SHALL equal program commit order.

Reset
REQ-027 While rst_ni is 0, count, pointers and occupancy_o SHALL be 0, update_valid_o SHALL be 0 and commit_ready_o SHALL be 1; payload storage SHALL not need reset.
REQ-028 A reset asserted mid-operation SHALL take effect immediately, losing queued updates; release SHALL be synchronised externally.

Structure
REQ-029 The shared package SHALL hold the loop_upd_t typedef {pc[31:0], taken}; NUM_LANES SHALL be derived from Cfg.INSTR_PER_FETCH at instantiation.
REQ-030 The lane compaction (prefix-count to slot offset) SHALL be one sub-module, loop_upd_compact; the queue SHALL stay inline.

Verification
REQ-031 Lanes 0 and 2 are cond (pc 0x100 T, 0x108 NT) and lanes 1 and 3 are non-cond -> the next two cycles emit 0x100/T then 0x108/NT, followed by valid 0.
REQ-032 Three all-cond groups are pushed back-to-back -> ready is 1, 1, then 0 once count reaches 7 (> 8 - 4); a group held during ready 0 is not enqueued; ready returns after the pops.
REQ-033 Pushes and pops continue for 20 cycles so the pointers wrap -> output PC sequence is identical to the input sequence, with no loss or duplication.
REQ-034 flush_i is asserted with 5 entries queued plus a push in the same cycle -> occupancy_o is 0 and update_valid_o is 0 on the next cycle.
REQ-035 rst_ni is dropped asynchronously mid-cycle with 6 entries queued -> outputs immediately show valid 0, ready 1, occupancy 0.
REQ-036 The bench is chained into loop_predictor with an 8-iteration loop pc 0x80 -> predict_confident_o asserts for the slot at 0x80 after the training converges.

Source files
------------

// File: rtl/loop_update_sched_pkg.sv
// rtl/loop_update_sched_pkg.sv - shared config record and loop-update payload type
package loop_update_sched_pkg;

    typedef struct packed {
        int unsigned INSTR_PER_FETCH;
        int unsigned NR_COMMIT_PORTS;
    } user_cfg_t;

    typedef struct packed {
        int unsigned INSTR_PER_FETCH;
        int unsigned NR_COMMIT_PORTS;
    } cfg_t;

    localparam user_cfg_t TestCfg = '{INSTR_PER_FETCH: 4, NR_COMMIT_PORTS: 2};

    function automatic cfg_t build_config(user_cfg_t user_cfg);
        cfg_t cfg;
        cfg.INSTR_PER_FETCH = user_cfg.INSTR_PER_FETCH;
        cfg.NR_COMMIT_PORTS = user_cfg.NR_COMMIT_PORTS;
        return cfg;
    endfunction

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
    } loop_upd_t;

endpackage

// File: rtl/loop_upd_compact.sv
// rtl/loop_upd_compact.sv - prefix count of qualifying lanes into dense slot offsets
module loop_upd_compact #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned CNT_W     = $clog2(NUM_LANES + 1)
) (
    input  logic [NUM_LANES-1:0]            qual,
    output logic [NUM_LANES-1:0][CNT_W-1:0] offset,
    output logic [CNT_W-1:0]                total
);

    logic [CNT_W-1:0] run;

    // Each lane lands after all older qualifying lanes, so skipped lanes leave no holes.
    always_comb begin
        run    = '0;
        offset = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            offset[i] = run;
            run       = run + CNT_W'(qual[i]);
        end
        total = run;
    end

endmodule

// File: rtl/loop_update_sched.sv
// rtl/loop_update_sched.sv - compacting queue of resolved conditional branches feeding the loop predictor
module loop_update_sched
    import loop_update_sched_pkg::*;
#(
    parameter cfg_t        Cfg       = build_config(TestCfg),
    parameter int unsigned NUM_LANES = Cfg.INSTR_PER_FETCH,
    parameter int unsigned DEPTH     = 8,
    localparam int unsigned PTR_W    = $clog2(DEPTH),
    localparam int unsigned OCC_W    = PTR_W + 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_LANES-1:0]       commit_valid_i,
    input  logic [NUM_LANES-1:0][31:0] commit_pc_i,
    input  logic [NUM_LANES-1:0]       commit_is_cond_i,
    input  logic [NUM_LANES-1:0]       commit_taken_i,
    output logic                       commit_ready_o,
    input  logic                       flush_i,
    output logic                       update_valid_o,
    output logic [31:0]                update_pc_o,
    output logic                       update_is_cond_o,
    output logic                       update_taken_o,
    output logic [OCC_W-1:0]           occupancy_o
);

    localparam int unsigned CNT_W = $clog2(NUM_LANES + 1);

    loop_upd_t                          mem [DEPTH];
    logic [PTR_W-1:0]                   wr_ptr;
    logic [PTR_W-1:0]                   rd_ptr;
    logic [OCC_W-1:0]                   count;
    logic [NUM_LANES-1:0]               qual;
    logic [NUM_LANES-1:0][CNT_W-1:0]    offset;
    logic [CNT_W-1:0]                   push_cnt;
    logic                               pop;
    loop_upd_t                          head;

    // A whole group is accepted or dropped, so space for every lane is required up front.
    assign commit_ready_o = (OCC_W'(DEPTH) - count) >= OCC_W'(NUM_LANES);
    assign qual           = commit_valid_i & commit_is_cond_i & {NUM_LANES{commit_ready_o}};
    assign pop            = (count != '0);
    assign head           = mem[rd_ptr];

    assign update_valid_o   = pop;
    assign update_is_cond_o = pop;
    assign update_pc_o      = pop ? head.pc : 32'd0;
    assign update_taken_o   = pop ? head.taken : 1'b0;
    assign occupancy_o      = count;

    loop_upd_compact #(
        .NUM_LANES (NUM_LANES),
        .CNT_W     (CNT_W)
    ) u_compact (
        .qual   (qual),
        .offset (offset),
        .total  (push_cnt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push_cnt);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + OCC_W'(push_cnt) - OCC_W'(pop);
        end
    end

    // Payload needs no reset: count gates every observable read.
    always_ff @(posedge clk_i) begin
        if (!flush_i) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (qual[i]) begin
                    mem[wr_ptr + PTR_W'(offset[i])] <= '{pc: commit_pc_i[i], taken: commit_taken_i[i]};
                end
            end
        end
    end

endmodule

// File: tb/tb_loop_update_sched.sv
// tb/tb_loop_update_sched.sv - scoreboard bench for loop_update_sched
module tb_loop_update_sched;
    import loop_update_sched_pkg::*;

    localparam cfg_t        Cfg   = build_config(TestCfg);
    localparam int unsigned NL    = Cfg.INSTR_PER_FETCH;
    localparam int unsigned DEPTH = 8;

    logic                clk_i = 1'b0;
    logic                rst_ni = 1'b0;
    logic [NL-1:0]       commit_valid_i = '0;
    logic [NL-1:0][31:0] commit_pc_i = '0;
    logic [NL-1:0]       commit_is_cond_i = '0;
    logic [NL-1:0]       commit_taken_i = '0;
    logic                commit_ready_o;
    logic                flush_i = 1'b0;
    logic                update_valid_o;
    logic [31:0]         update_pc_o;
    logic                update_is_cond_o;
    logic                update_taken_o;
    logic [3:0]          occupancy_o;

    loop_update_sched #(
        .Cfg       (Cfg),
        .NUM_LANES (NL),
        .DEPTH     (DEPTH)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .commit_valid_i   (commit_valid_i),
        .commit_pc_i      (commit_pc_i),
        .commit_is_cond_i (commit_is_cond_i),
        .commit_taken_i   (commit_taken_i),
        .commit_ready_o   (commit_ready_o),
        .flush_i          (flush_i),
        .update_valid_o   (update_valid_o),
        .update_pc_o      (update_pc_o),
        .update_is_cond_o (update_is_cond_o),
        .update_taken_o   (update_taken_o),
        .occupancy_o      (occupancy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;
    loop_upd_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every displayed update must match the oldest expected entry.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (update_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("mon_unexpected_update", {31'd0, update_valid_o}, 32'd0);
                end else begin
                    loop_upd_t e;
                    e = exp_q.pop_front();
                    chk("mon_pc", update_pc_o, e.pc);
                    chk("mon_taken", {31'd0, update_taken_o}, {31'd0, e.taken});
                    chk("mon_is_cond", {31'd0, update_is_cond_o}, 32'd1);
                end
            end else begin
                chk("mon_idle_pc", update_pc_o, 32'd0);
                chk("mon_idle_taken", {31'd0, update_taken_o}, 32'd0);
            end
        end
    end

    function automatic logic [NL-1:0][31:0] mk_pcs(input logic [31:0] base);
        logic [NL-1:0][31:0] p;
        for (int i = 0; i < NL; i++) p[i] = base + 32'(4 * i);
        return p;
    endfunction

    // Called at posedge+1; presents one group for one cycle and returns at the next posedge+1.
    task automatic drive_cycle(input logic [NL-1:0] v, input logic [NL-1:0] c,
                               input logic [NL-1:0] t, input logic [NL-1:0][31:0] p,
                               output bit accepted);
        bit mready;
        commit_valid_i   = v;
        commit_is_cond_i = c;
        commit_taken_i   = t;
        commit_pc_i      = p;
        mready = (DEPTH - exp_q.size()) >= NL;
        chk("ready_model", {31'd0, commit_ready_o}, {31'd0, mready});
        if (mready) begin
            for (int i = 0; i < NL; i++)
                if (v[i] && c[i]) exp_q.push_back('{pc: p[i], taken: t[i]});
        end
        accepted = mready;
        @(posedge clk_i); #1;
        commit_valid_i = '0;
        commit_is_cond_i = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i); #1;
        end
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || update_valid_o) && k < 20) begin
            idle(1);
            k++;
        end
        chk(name, exp_q.size(), 0);
        chk({name, "_occ"}, {28'd0, occupancy_o}, 32'd0);
    endtask

    logic [NL-1:0] mask_tab [20] = '{4'b0101, 4'b0000, 4'b1000, 4'b0010, 4'b1111,
                                     4'b0000, 4'b0000, 4'b0001, 4'b0110, 4'b0000,
                                     4'b0100, 4'b1001, 4'b0000, 4'b0011, 4'b0000,
                                     4'b1110, 4'b0000, 4'b0000, 4'b1000, 4'b0101};

    initial begin
        bit acc;
        int tries;

        // Reset state
        #2;
        chk("rst_valid", {31'd0, update_valid_o}, 32'd0);
        chk("rst_ready", {31'd0, commit_ready_o}, 32'd1);
        chk("rst_occ", {28'd0, occupancy_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        idle(1);

        // Lanes 0/2 conditional, 1/3 not: two updates in lane order, then idle
        drive_cycle(4'b1111, 4'b0101, 4'b0001, '{32'h10c, 32'h108, 32'h104, 32'h100}, acc);
        chk("t31_v0", {31'd0, update_valid_o}, 32'd1);
        chk("t31_pc0", update_pc_o, 32'h100);
        chk("t31_tk0", {31'd0, update_taken_o}, 32'd1);
        idle(1);
        chk("t31_pc1", update_pc_o, 32'h108);
        chk("t31_tk1", {31'd0, update_taken_o}, 32'd0);
        idle(1);
        chk("t31_v2", {31'd0, update_valid_o}, 32'd0);

        // Back-to-back full groups hit the ready threshold at count 7
        chk("t32_rdy0", {31'd0, commit_ready_o}, 32'd1);
        drive_cycle(4'b1111, 4'b1111, 4'b1010, mk_pcs(32'h200), acc);
        chk("t32_rdy1", {31'd0, commit_ready_o}, 32'd1);
        drive_cycle(4'b1111, 4'b1111, 4'b0110, mk_pcs(32'h300), acc);
        chk("t32_occ7", {28'd0, occupancy_o}, 32'd7);
        chk("t32_rdy2", {31'd0, commit_ready_o}, 32'd0);
        tries = 0;
        acc = 1'b0;
        while (!acc && tries < 10) begin
            drive_cycle(4'b1111, 4'b1111, 4'b1001, mk_pcs(32'h400), acc);
            tries++;
        end
        chk("t32_tries", tries, 4);
        drain("t32_drain");

        // Twenty cycles of mixed pushes so both pointers wrap
        for (int i = 0; i < 20; i++)
            drive_cycle(4'b1111, mask_tab[i], 4'(i), mk_pcs(32'h1000 + 32'(i * 16)), acc);
        drain("t33_drain");

        // Flush with five queued and a group presented
        drive_cycle(4'b1111, 4'b1111, 4'b0000, mk_pcs(32'h500), acc);
        drive_cycle(4'b1111, 4'b0011, 4'b0011, mk_pcs(32'h600), acc);
        chk("t34_occ5", {28'd0, occupancy_o}, 32'd5);
        flush_i = 1'b1;
        commit_valid_i = 4'b1111;
        commit_is_cond_i = 4'b1111;
        commit_pc_i = mk_pcs(32'h700);
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        commit_valid_i = '0;
        exp_q.delete();
        chk("t34_occ", {28'd0, occupancy_o}, 32'd0);
        chk("t34_valid", {31'd0, update_valid_o}, 32'd0);
        idle(2);

        // Asynchronous reset mid-cycle with six queued
        drive_cycle(4'b1111, 4'b1111, 4'b0101, mk_pcs(32'h800), acc);
        drive_cycle(4'b1111, 4'b0111, 4'b0010, mk_pcs(32'h900), acc);
        chk("t35_occ6", {28'd0, occupancy_o}, 32'd6);
        #2;
        rst_ni = 1'b0;
        exp_q.delete();
        #1;
        chk("t35_valid", {31'd0, update_valid_o}, 32'd0);
        chk("t35_ready", {31'd0, commit_ready_o}, 32'd1);
        chk("t35_occ", {28'd0, occupancy_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        // Queue still works after reset
        drive_cycle(4'b0011, 4'b0011, 4'b0010, mk_pcs(32'ha00), acc);
        drain("post_rst_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1);
    end

endmodule
